// File: rtl/sirv_sram_2to1_arb.sv
// Two-requester arbiter in front of a single 1-cycle SRAM controller port.
// Commands are granted round-robin or fixed-priority; an owner FIFO steers in-order responses back.
module sirv_sram_2to1_arb #(
  parameter int DW     = 32,
  parameter int MW     = 4,
  parameter int AW     = 32,
  parameter int USR_W  = 3,
  parameter int OUTS   = 2,
  parameter int ARB_RR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_cmd_valid,
  output logic             m0_cmd_ready,
  input  logic             m0_cmd_read,
  input  logic [AW-1:0]    m0_cmd_addr,
  input  logic [DW-1:0]    m0_cmd_wdata,
  input  logic [MW-1:0]    m0_cmd_wmask,
  input  logic [USR_W-1:0] m0_cmd_usr,
  output logic             m0_rsp_valid,
  input  logic             m0_rsp_ready,
  output logic [DW-1:0]    m0_rsp_rdata,
  output logic [USR_W-1:0] m0_rsp_usr,
  input  logic             m1_cmd_valid,
  output logic             m1_cmd_ready,
  input  logic             m1_cmd_read,
  input  logic [AW-1:0]    m1_cmd_addr,
  input  logic [DW-1:0]    m1_cmd_wdata,
  input  logic [MW-1:0]    m1_cmd_wmask,
  input  logic [USR_W-1:0] m1_cmd_usr,
  output logic             m1_rsp_valid,
  input  logic             m1_rsp_ready,
  output logic [DW-1:0]    m1_rsp_rdata,
  output logic [USR_W-1:0] m1_rsp_usr,
  output logic             uop_cmd_valid,
  input  logic             uop_cmd_ready,
  output logic             uop_cmd_read,
  output logic [AW-1:0]    uop_cmd_addr,
  output logic [DW-1:0]    uop_cmd_wdata,
  output logic [MW-1:0]    uop_cmd_wmask,
  output logic [USR_W-1:0] uop_cmd_usr,
  input  logic             uop_rsp_valid,
  output logic             uop_rsp_ready,
  input  logic [DW-1:0]    uop_rsp_rdata,
  input  logic [USR_W-1:0] uop_rsp_usr,
  output logic             arb_active
);

  localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int CW = $clog2(OUTS + 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(OUTS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(OUTS);

  logic            rr_ptr;
  logic [OUTS-1:0] route;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;

  logic any_vld;
  logic winner;
  logic owner;
  logic fifo_empty;
  logic can_push;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  // Grant and steering are purely combinational: no cycle is added on either path.
  always_comb begin
    any_vld = m0_cmd_valid | m1_cmd_valid;
    if (m0_cmd_valid && m1_cmd_valid) winner = (ARB_RR != 0) ? rr_ptr : 1'b0;
    else                              winner = m1_cmd_valid;

    fifo_empty    = (count == '0);
    owner         = route[rptr];
    uop_rsp_ready = ~rst & ~fifo_empty & (owner ? m1_rsp_ready : m0_rsp_ready);
    pop           = uop_rsp_valid & uop_rsp_ready;

    // A response retiring this cycle frees a slot for a same-cycle command.
    can_push      = (count < CNT_MAX) | pop;
    uop_cmd_valid = ~rst & any_vld & can_push;
    m0_cmd_ready  = ~rst & ~winner & uop_cmd_ready & can_push;
    m1_cmd_ready  = ~rst &  winner & uop_cmd_ready & can_push;
    push          = uop_cmd_valid & uop_cmd_ready;

    m0_rsp_valid  = ~rst & uop_rsp_valid & ~fifo_empty & ~owner;
    m1_rsp_valid  = ~rst & uop_rsp_valid & ~fifo_empty &  owner;
    arb_active    = ~rst & (any_vld | ~fifo_empty);
  end

  assign uop_cmd_read  = winner ? m1_cmd_read  : m0_cmd_read;
  assign uop_cmd_addr  = winner ? m1_cmd_addr  : m0_cmd_addr;
  assign uop_cmd_wdata = winner ? m1_cmd_wdata : m0_cmd_wdata;
  assign uop_cmd_wmask = winner ? m1_cmd_wmask : m0_cmd_wmask;
  assign uop_cmd_usr   = winner ? m1_cmd_usr   : m0_cmd_usr;

  assign m0_rsp_rdata = uop_rsp_rdata;
  assign m1_rsp_rdata = uop_rsp_rdata;
  assign m0_rsp_usr   = uop_rsp_usr;
  assign m1_rsp_usr   = uop_rsp_usr;

  // Control state: favoured requester and route-FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wptr <= ptr_inc(wptr);
        if (ARB_RR != 0) rr_ptr <= ~winner;
      end
      if (pop) rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Owner ids carry no reset; only entries between rptr and wptr are ever read.
  always_ff @(posedge clk) begin
    if (push) route[wptr] <= winner;
  end

  a_rsp_without_owner : assert property (@(posedge clk) disable iff (rst)
    !(uop_rsp_valid && fifo_empty))
    else $error("uop_rsp_valid asserted with no outstanding command");

endmodule

// File: tb/tb_sirv_sram_2to1_arb.sv
// Directed bench for sirv_sram_2to1_arb: a queued SRAM model behind a round-robin instance,
// plus a fixed-priority instance sharing the same requester inputs.
module tb_sirv_sram_2to1_arb;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
  logic [31:0] m0_cmd_addr, m0_cmd_wdata;
  logic [3:0]  m0_cmd_wmask;
  logic [2:0]  m0_cmd_usr;
  logic        m0_rsp_valid, m0_rsp_ready;
  logic [31:0] m0_rsp_rdata;
  logic [2:0]  m0_rsp_usr;
  logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
  logic [31:0] m1_cmd_addr, m1_cmd_wdata;
  logic [3:0]  m1_cmd_wmask;
  logic [2:0]  m1_cmd_usr;
  logic        m1_rsp_valid, m1_rsp_ready;
  logic [31:0] m1_rsp_rdata;
  logic [2:0]  m1_rsp_usr;
  logic        uop_cmd_valid, uop_cmd_ready, uop_cmd_read;
  logic [31:0] uop_cmd_addr, uop_cmd_wdata;
  logic [3:0]  uop_cmd_wmask;
  logic [2:0]  uop_cmd_usr;
  logic        uop_rsp_valid, uop_rsp_ready;
  logic [31:0] uop_rsp_rdata;
  logic [2:0]  uop_rsp_usr;
  logic        arb_active;

  // Fixed-priority instance signals
  logic        f_one = 1'b1;
  logic [31:0] f_zero_d = '0;
  logic [2:0]  f_zero_u = '0;
  logic        f_m0_cmd_ready, f_m1_cmd_ready, f_m0_rsp_valid, f_m1_rsp_valid;
  logic [31:0] f_m0_rsp_rdata, f_m1_rsp_rdata;
  logic [2:0]  f_m0_rsp_usr, f_m1_rsp_usr;
  logic        f_uop_cmd_valid, f_uop_cmd_read, f_uop_rsp_valid, f_uop_rsp_ready, f_arb_active;
  logic [31:0] f_uop_cmd_addr, f_uop_cmd_wdata;
  logic [3:0]  f_uop_cmd_wmask;
  logic [2:0]  f_uop_cmd_usr;
  logic [3:0]  f_pend;

  // SRAM model: 16-word memory, responses queued in command order
  logic [31:0] mem [16];
  logic [31:0] rq_data [8];
  logic [2:0]  rq_usr [8];
  logic [3:0]  rq_h, rq_t;

  always #5 clk = ~clk;

  sirv_sram_2to1_arb #(.DW(32), .MW(4), .AW(32), .USR_W(3), .OUTS(2), .ARB_RR(1)) dut (
    .clk(clk), .rst(rst),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
    .m0_cmd_usr(m0_cmd_usr), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
    .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_usr(m0_rsp_usr),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
    .m1_cmd_usr(m1_cmd_usr), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
    .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_usr(m1_rsp_usr),
    .uop_cmd_valid(uop_cmd_valid), .uop_cmd_ready(uop_cmd_ready), .uop_cmd_read(uop_cmd_read),
    .uop_cmd_addr(uop_cmd_addr), .uop_cmd_wdata(uop_cmd_wdata), .uop_cmd_wmask(uop_cmd_wmask),
    .uop_cmd_usr(uop_cmd_usr), .uop_rsp_valid(uop_rsp_valid), .uop_rsp_ready(uop_rsp_ready),
    .uop_rsp_rdata(uop_rsp_rdata), .uop_rsp_usr(uop_rsp_usr), .arb_active(arb_active)
  );

  sirv_sram_2to1_arb #(.DW(32), .MW(4), .AW(32), .USR_W(3), .OUTS(2), .ARB_RR(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(f_m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
    .m0_cmd_usr(m0_cmd_usr), .m0_rsp_valid(f_m0_rsp_valid), .m0_rsp_ready(f_one),
    .m0_rsp_rdata(f_m0_rsp_rdata), .m0_rsp_usr(f_m0_rsp_usr),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(f_m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
    .m1_cmd_usr(m1_cmd_usr), .m1_rsp_valid(f_m1_rsp_valid), .m1_rsp_ready(f_one),
    .m1_rsp_rdata(f_m1_rsp_rdata), .m1_rsp_usr(f_m1_rsp_usr),
    .uop_cmd_valid(f_uop_cmd_valid), .uop_cmd_ready(f_one), .uop_cmd_read(f_uop_cmd_read),
    .uop_cmd_addr(f_uop_cmd_addr), .uop_cmd_wdata(f_uop_cmd_wdata),
    .uop_cmd_wmask(f_uop_cmd_wmask), .uop_cmd_usr(f_uop_cmd_usr),
    .uop_rsp_valid(f_uop_rsp_valid), .uop_rsp_ready(f_uop_rsp_ready),
    .uop_rsp_rdata(f_zero_d), .uop_rsp_usr(f_zero_u), .arb_active(f_arb_active)
  );

  assign uop_rsp_valid   = (rq_h != rq_t);
  assign uop_rsp_rdata   = rq_data[rq_h[2:0]];
  assign uop_rsp_usr     = rq_usr[rq_h[2:0]];
  assign f_uop_rsp_valid = (f_pend != 4'd0);

  always @(posedge clk) begin
    if (rst) begin
      rq_h    <= '0;
      rq_t    <= '0;
      mem[4]  <= 32'h1111_0010;
      mem[8]  <= 32'h2222_0020;
      mem[12] <= 32'h0;
    end else begin
      if (uop_rsp_valid && uop_rsp_ready) rq_h <= rq_h + 4'd1;
      if (uop_cmd_valid && uop_cmd_ready) begin
        rq_data[rq_t[2:0]] <= uop_cmd_read ? mem[uop_cmd_addr[5:2]] : 32'h0;
        rq_usr[rq_t[2:0]]  <= uop_cmd_usr;
        rq_t <= rq_t + 4'd1;
        if (!uop_cmd_read)
          for (int b = 0; b < 4; b++)
            if (uop_cmd_wmask[b]) mem[uop_cmd_addr[5:2]][8*b +: 8] <= uop_cmd_wdata[8*b +: 8];
      end
    end
  end

  always @(posedge clk) begin
    if (rst) f_pend <= '0;
    else     f_pend <= f_pend + {3'b0, f_uop_cmd_valid} - {3'b0, f_uop_rsp_valid & f_uop_rsp_ready};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    uop_cmd_ready = 1'b1;
    m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    m0_cmd_valid = 1'b1; m0_cmd_read = 1'b1; m0_cmd_addr = 32'h10;
    m0_cmd_wdata = '0;   m0_cmd_wmask = '0;  m0_cmd_usr = 3'd1;
    m1_cmd_valid = 1'b1; m1_cmd_read = 1'b1; m1_cmd_addr = 32'h20;
    m1_cmd_wdata = '0;   m1_cmd_wmask = '0;  m1_cmd_usr = 3'd2;

    // 1: reset with both requesters valid
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_outs", {m0_cmd_ready, m1_cmd_ready, uop_cmd_valid, m0_rsp_valid,
                       m1_rsp_valid, uop_rsp_ready, arb_active}, 7'b0);
    end
    rst = 1'b0; #1;
    chk("rst_first_grant", {m1_cmd_ready, m0_cmd_ready}, 2'b01);
    chk("rst_first_addr", uop_cmd_addr, 32'h10);
    m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b0;
    @(negedge clk);

    // 2: round-robin contention, responses routed next cycle
    m0_cmd_valid = 1'b1; m1_cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", {m1_cmd_ready, m0_cmd_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        chk("rr_rsp_owner", {m1_rsp_valid, m0_rsp_valid}, (i % 2 == 1) ? 2'b01 : 2'b10);
        chk("rr_rsp_data", m0_rsp_rdata, (i % 2 == 1) ? 32'h1111_0010 : 32'h2222_0020);
        chk("rr_rsp_usr", m1_rsp_usr, (i % 2 == 1) ? 3'd1 : 3'd2);
      end
      tick();
    end
    m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b0; #1;
    chk("rr_last_rsp", {m1_rsp_valid, m0_rsp_valid}, 2'b10);
    chk("rr_last_data", m1_rsp_rdata, 32'h2222_0020);
    tick(); #1;
    chk("rr_idle", arb_active, 1'b0);

    // 3: fixed priority keeps m1 out while m0 stays valid
    m0_cmd_valid = 1'b1; m1_cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_grant", {f_m1_cmd_ready, f_m0_cmd_ready}, 2'b01);
      tick();
    end
    m0_cmd_valid = 1'b0; #1;
    chk("fp_m1_after_drop", f_m1_cmd_ready, 1'b1);
    m1_cmd_valid = 1'b0;
    tick(); tick(); #1;
    chk("fp_idle", arb_active, 1'b0);

    // 4: full route FIFO, then simultaneous pop and push
    m0_rsp_ready = 1'b0;
    m0_cmd_valid = 1'b1; #1;
    chk("full_cmd1", uop_cmd_valid, 1'b1);
    tick(); #1;
    chk("full_cmd2", uop_cmd_valid, 1'b1);
    tick(); #1;
    chk("full_cmd3_blocked", {uop_cmd_valid, m0_cmd_ready}, 2'b00);
    chk("full_cnt", dut.count, 2);
    m0_rsp_ready = 1'b1; #1;
    chk("full_push_pop", {uop_cmd_valid, m0_cmd_ready, uop_rsp_ready}, 3'b111);
    tick(); #1;
    chk("full_cnt_hold", dut.count, 2);
    m0_cmd_valid = 1'b0;
    tick(); tick(); tick(); #1;
    chk("full_drained", {dut.count, arb_active}, 0);

    // 5: head-of-line blocking, then write/readback for m1
    m0_rsp_ready = 1'b0;
    m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h10;
    tick();
    m0_cmd_valid = 1'b0;
    m1_cmd_valid = 1'b1; m1_cmd_read = 1'b0; m1_cmd_addr = 32'h30;
    m1_cmd_wdata = 32'hA5A5_A5A5; m1_cmd_wmask = 4'hF; #1;
    chk("hol_m1_cmd", m1_cmd_ready, 1'b1);
    tick();
    m1_cmd_valid = 1'b0; #1;
    chk("hol_blocked1", {m1_rsp_valid, m0_rsp_valid}, 2'b01);
    tick(); #1;
    chk("hol_blocked2", {m1_rsp_valid, m0_rsp_valid}, 2'b01);
    m0_rsp_ready = 1'b1; #1;
    chk("hol_m0_accept", uop_rsp_ready, 1'b1);
    tick(); #1;
    chk("hol_m1_released", {m1_rsp_valid, m0_rsp_valid}, 2'b10);
    tick();
    m1_cmd_valid = 1'b1; m1_cmd_read = 1'b1; #1;
    chk("hol_rd_cmd", m1_cmd_ready, 1'b1);
    tick();
    m1_cmd_valid = 1'b0; #1;
    chk("hol_rd_valid", m1_rsp_valid, 1'b1);
    chk("hol_rd_data", m1_rsp_rdata, 32'hA5A5_A5A5);
    tick();

    // 6: reset with two commands outstanding
    m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
    m1_cmd_valid = 1'b1; m1_cmd_addr = 32'h20;
    tick();
    m1_cmd_valid = 1'b0; m0_cmd_valid = 1'b1; #1;
    chk("mid_m0_cmd", m0_cmd_ready, 1'b1);
    tick();
    m0_cmd_valid = 1'b0; #1;
    chk("mid_state", {dut.count, dut.rr_ptr}, {2'd2, 1'b1});
    rst = 1'b1; #1;
    chk("mid_rst_forced", {m0_rsp_valid, m1_rsp_valid, uop_rsp_ready}, 3'b000);
    tick(); #1;
    chk("mid_cleared", {dut.count, dut.rr_ptr}, 0);
    rst = 1'b0; m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1; #1;
    chk("mid_no_stale", {m0_rsp_valid, m1_rsp_valid, uop_rsp_valid, arb_active}, 4'b0);
    m0_cmd_valid = 1'b1; m1_cmd_valid = 1'b1; #1;
    chk("mid_grant_m0", {m1_cmd_ready, m0_cmd_ready}, 2'b01);
    m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
